// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the execute stage.
// A mult/div command samples its operands and computes the full 64-bit result
// at the start edge. The result is parked in a pending register and only
// committed to HI/LO once the fixed busy window has expired. This mimics the
// latency of an iterative unit while keeping the datapath trivially simple.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [2*DATA_W-1:0]     pend_q, pend_d;
  logic                    pend_we_q, pend_we_d;
  logic [DATA_W-1:0]       hi_q, hi_d;
  logic [DATA_W-1:0]       lo_q, lo_d;

  // Full 64-bit product. Both operands are extended to 64 bits first, so a
  // single 64x64 multiplier gives the correct low 64 bits for signed and
  // unsigned forms.
  function automatic logic [2*DATA_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic              sgn);
    logic [2*DATA_W-1:0] ea, eb;
    ea = sgn ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    eb = sgn ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Divide returning {remainder, quotient}. The signed form divides the
  // magnitudes and then restores the signs: the quotient is truncated toward
  // zero and the remainder follows the dividend. For 0x80000000 / -1 the
  // negated magnitude wraps back to 0x80000000 with remainder 0, which is the
  // defined overflow result. A zero divisor yields 0 here; the caller
  // suppresses the write in that case.
  function automatic logic [2*DATA_W-1:0] div_full(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic              sgn);
    logic              neg_a, neg_b;
    logic [DATA_W-1:0] ma, mb, q, r;
    neg_a = sgn & a[DATA_W-1];
    neg_b = sgn & b[DATA_W-1];
    ma    = neg_a ? (~a + 1'b1) : a;
    mb    = neg_b ? (~b + 1'b1) : b;
    if (mb == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (neg_a ^ neg_b) q = ~q + 1'b1;
    if (neg_a)         r = ~r + 1'b1;
    return {r, q};
  endfunction

  // Next-state logic: command decode in IDLE, countdown and commit in RUN.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_d    = mul_full(src_a, src_b, op == OP_MULT);
              pend_we_d = 1'b1;
              cnt_d     = 5'(MULT_CYCLES);
              busy_d    = 1'b1;
              state_d   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_d    = div_full(src_a, src_b, op == OP_DIV);
              pend_we_d = (src_b != '0);
              cnt_d     = 5'(DIV_CYCLES);
              busy_d    = 1'b1;
              state_d   = RUN;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Commands arriving here are dropped; the stall upstream prevents them.
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          pend_we_d = 1'b0;
          if (pend_we_q) begin
            hi_d = pend_q[2*DATA_W-1:DATA_W];
            lo_d = pend_q[DATA_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears everything, aborting any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: reset, latency, arithmetic and edge cases.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi, lo, rd_data;

  int cmp_cnt = 0;
  int err_cnt = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .rd_sel(rd_sel), .busy(busy), .hi(hi), .lo(lo),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start strobe; returns at the negedge after the start edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges (from the current one) at which busy is high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    cmp_cnt++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_mult;
    issue(3'd0, 32'd3, 32'd4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    cmp_cnt++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_mid_mult: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    cmp_cnt++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_no_late_update: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_mult;
    int n;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    cmp_cnt++;
    if (n !== 5) begin
      err_cnt++;
      $display("FAIL mult_latency: busy cycles %0d, required 5", n);
    end
    rd_sel = 1'b0;
    #1;
    cmp_cnt++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA || rd_data !== 32'hFFFFFFFA) begin
      err_cnt++;
      $display("FAIL mult_result: hi=%h lo=%h rd=%h, required ffffffff/fffffffa/fffffffa", hi, lo, rd_data);
    end
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    cmp_cnt++;
    if (busy !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      err_cnt++;
      $display("FAIL multu_hold: busy=%b hi=%h lo=%h, required 1/ffffffff/fffffffa", busy, hi, lo);
    end
    wait_idle(n);
    cmp_cnt++;
    if (n !== 5) begin
      err_cnt++;
      $display("FAIL multu_latency: busy cycles %0d, required 5", n);
    end
    cmp_cnt++;
    if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
      err_cnt++;
      $display("FAIL multu_result: hi=%h lo=%h, required 00000002/fffffffa", hi, lo);
    end
  endtask

  task automatic test_div;
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    cmp_cnt++;
    if (n !== 10) begin
      err_cnt++;
      $display("FAIL div_latency: busy cycles %0d, required 10", n);
    end
    cmp_cnt++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      err_cnt++;
      $display("FAIL div_result: hi=%h lo=%h, required ffffffff/fffffffd", hi, lo);
    end
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    cmp_cnt++;
    if (n !== 10 || hi !== 32'd2 || lo !== 32'd14) begin
      err_cnt++;
      $display("FAIL divu_result: cycles=%0d hi=%h lo=%h, required 10/00000002/0000000e", n, hi, lo);
    end
  endtask

  task automatic test_div_edge;
    int n;
    issue(3'd4, 32'hAAAA0000, 32'd0);
    issue(3'd5, 32'h00005555, 32'd0);
    issue(3'd2, 32'd5, 32'd0);
    wait_idle(n);
    cmp_cnt++;
    if (n !== 10) begin
      err_cnt++;
      $display("FAIL div0_latency: busy cycles %0d, required 10", n);
    end
    cmp_cnt++;
    if (hi !== 32'hAAAA0000 || lo !== 32'h00005555) begin
      err_cnt++;
      $display("FAIL div0_no_write: hi=%h lo=%h, required aaaa0000/00005555", hi, lo);
    end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    cmp_cnt++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin
      err_cnt++;
      $display("FAIL div_overflow: hi=%h lo=%h, required 00000000/80000000", hi, lo);
    end
  endtask

  task automatic test_start_while_busy;
    int n;
    issue(3'd0, 32'd2, 32'd2);
    start = 1'b1; op = 3'd2; src_a = 32'd9; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    cmp_cnt++;
    if (n + 1 !== 5) begin
      err_cnt++;
      $display("FAIL busy_ignore_latency: busy cycles %0d, required 5", n + 1);
    end
    cmp_cnt++;
    if (hi !== 32'h0 || lo !== 32'd4) begin
      err_cnt++;
      $display("FAIL busy_ignore_result: hi=%h lo=%h, required 00000000/00000004", hi, lo);
    end
    repeat (8) @(negedge clk);
    cmp_cnt++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd4) begin
      err_cnt++;
      $display("FAIL busy_ignore_no_div: busy=%b hi=%h lo=%h, required 0/00000000/00000004", busy, hi, lo);
    end
  endtask

  task automatic test_move_and_read;
    issue(3'd5, 32'h12345678, 32'd0);
    rd_sel = 1'b0;
    #1;
    cmp_cnt++;
    if (busy !== 1'b0 || rd_data !== 32'h12345678) begin
      err_cnt++;
      $display("FAIL mtlo_read: busy=%b rd=%h, required 0/12345678", busy, rd_data);
    end
    issue(3'd4, 32'hCAFEF00D, 32'd0);
    rd_sel = 1'b1;
    #1;
    cmp_cnt++;
    if (busy !== 1'b0 || rd_data !== 32'hCAFEF00D) begin
      err_cnt++;
      $display("FAIL mthi_read: busy=%b rd=%h, required 0/cafef00d", busy, rd_data);
    end
    rd_sel = 1'b0;
    #1;
    cmp_cnt++;
    if (rd_data !== 32'h12345678) begin
      err_cnt++;
      $display("FAIL lo_reread: rd=%h, required 12345678", rd_data);
    end
  endtask

  task automatic test_reserved;
    issue(3'd6, 32'hDEADBEEF, 32'd1);
    cmp_cnt++;
    if (busy !== 1'b0 || hi !== 32'hCAFEF00D || lo !== 32'h12345678) begin
      err_cnt++;
      $display("FAIL reserved_op6: busy=%b hi=%h lo=%h, required 0/cafef00d/12345678", busy, hi, lo);
    end
    issue(3'd7, 32'hDEADBEEF, 32'd1);
    cmp_cnt++;
    if (busy !== 1'b0 || hi !== 32'hCAFEF00D || lo !== 32'h12345678) begin
      err_cnt++;
      $display("FAIL reserved_op7: busy=%b hi=%h lo=%h, required 0/cafef00d/12345678", busy, hi, lo);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0; rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_reset_mid_mult();
    test_mult();
    test_div();
    test_div_edge();
    test_start_while_busy();
    test_move_and_read();
    test_reserved();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
